mem_stage: RTL and testbench

- Memory-access stage placed directly downstream of the execute stage.
- Consumes the registered ALU result (effective address), store data, opcode and control bits from execute.
- Runs byte/half/word loads and stores over a req/ack data-memory port, stalling upstream while an access is outstanding.
- Registers the MEM/WB pipeline outputs for writeback.

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores over a req/ack data port,
// stalling upstream while an access is outstanding, with registered MEM/WB outputs.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Result_mem,
  input  logic [31:0] mem_data_ex,
  input  logic [5:0]  opcode_ex,
  input  logic        MemWrite_mem,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  logic [4:0]  towrite_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_towrite,
  output logic        wb_regwrite,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [4:0]       towrite_q, towrite_d;
  logic             regwrite_q, regwrite_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       wb_towrite_q, wb_towrite_d;
  logic             wb_regwrite_q, wb_regwrite_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;

  logic        is_mem, size_half, size_word, misaligned, timeout_hit, stall;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        unused_opcode;

  assign unused_opcode = ^opcode_ex[5:3];

  assign is_mem     = MemWrite_mem | MemtoReg_mem;
  assign size_half  = (opcode_ex[1:0] == 2'b01);
  assign size_word  = opcode_ex[1];
  assign misaligned = (size_half & Result_mem[0]) | (size_word & (|Result_mem[1:0]));

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = mem_data_ex;
    case (opcode_ex[1:0])
      2'b00: begin
        be_in    = 4'b0001 << Result_mem[1:0];
        wdata_in = {4{mem_data_ex[7:0]}};
      end
      2'b01: begin
        be_in    = Result_mem[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{mem_data_ex[15:0]}};
      end
      default: ;
    endcase
  end

  // Little-endian lane extraction from the latched address.
  always_comb begin
    rd_byte = dmem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      2'd3:    rd_byte = dmem_rdata[31:24];
      default: ;
    endcase
    rd_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = dmem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    uns_d         = uns_q;
    towrite_d     = towrite_q;
    regwrite_d    = regwrite_q;
    // WB registers take a bubble unless a result is retired this edge.
    wb_data_d     = 32'h0;
    wb_towrite_d  = 5'd0;
    wb_regwrite_d = 1'b0;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;
    stall         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            stall      = 1'b1;
            addr_d     = Result_mem;
            we_d       = MemWrite_mem;
            be_d       = be_in;
            wdata_d    = wdata_in;
            size_d     = opcode_ex[1:0];
            uns_d      = opcode_ex[2];
            towrite_d  = towrite_ex;
            regwrite_d = RegWrite_mem & ~MemWrite_mem;
            cnt_d      = '0;
            state_d    = StWait;
          end
        end else begin
          wb_data_d     = Result_mem;
          wb_towrite_d  = towrite_ex;
          wb_regwrite_d = RegWrite_mem & (|towrite_ex);
        end
      end
      StWait: begin
        if (timeout_hit) begin
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (dmem_ack) begin
          state_d = StIdle;
          if (!we_q) begin
            wb_data_d     = load_data;
            wb_towrite_d  = towrite_q;
            wb_regwrite_d = regwrite_q & (|towrite_q);
          end
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= 32'h0;
      we_q          <= 1'b0;
      be_q          <= 4'h0;
      wdata_q       <= 32'h0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      towrite_q     <= 5'd0;
      regwrite_q    <= 1'b0;
      wb_data_q     <= 32'h0;
      wb_towrite_q  <= 5'd0;
      wb_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      towrite_q     <= towrite_d;
      regwrite_q    <= regwrite_d;
      wb_data_q     <= wb_data_d;
      wb_towrite_q  <= wb_towrite_d;
      wb_regwrite_q <= wb_regwrite_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Reset gates the combinational outputs so they drop while reset is still held.
  assign dmem_req    = ~reset & (state_q == StWait) & ~timeout_hit;
  assign stall_mem   = ~reset & stall;
  assign dmem_we     = we_q;
  assign dmem_addr   = {addr_q[31:2], 2'b00};
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign wb_data     = wb_data_q;
  assign wb_towrite  = wb_towrite_q;
  assign wb_regwrite = wb_regwrite_q;
  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misalignment, timeout, reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Result_mem, mem_data_ex, dmem_rdata;
  logic [5:0]  opcode_ex;
  logic        MemWrite_mem, MemtoReg_mem, RegWrite_mem, dmem_ack;
  logic [4:0]  towrite_ex;
  logic        dmem_req, dmem_we, stall_mem, wb_regwrite, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_towrite;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .Result_mem   (Result_mem),
    .mem_data_ex  (mem_data_ex),
    .opcode_ex    (opcode_ex),
    .MemWrite_mem (MemWrite_mem),
    .MemtoReg_mem (MemtoReg_mem),
    .RegWrite_mem (RegWrite_mem),
    .towrite_ex   (towrite_ex),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall_mem    (stall_mem),
    .wb_data      (wb_data),
    .wb_towrite   (wb_towrite),
    .wb_regwrite  (wb_regwrite),
    .misalign     (misalign),
    .bus_err      (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic mw, input logic mr, input logic rw, input logic [4:0] rd);
    opcode_ex    = op;
    Result_mem   = addr;
    mem_data_ex  = data;
    MemWrite_mem = mw;
    MemtoReg_mem = mr;
    RegWrite_mem = rw;
    towrite_ex   = rd;
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    set_op(6'b000000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall_mem}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    reset = 1'b0;

    // ALU pass-through
    set_op(6'b000000, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    chk("alu_stall", {31'h0, stall_mem}, 32'h0);
    chk("alu_req", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("alu_wb_data", wb_data, 32'h0000_1234);
    chk("alu_wb_towrite", {27'h0, wb_towrite}, 32'd5);
    chk("alu_wb_regwrite", {31'h0, wb_regwrite}, 32'h1);

    // Register 0 never written
    set_op(6'b000000, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    chk("r0_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);

    // lb 0x103, ack on the third WAIT cycle
    set_op(6'b100000, 32'h0000_0103, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
    dmem_rdata = 32'h80FF_0000;
    #1;
    chk("lb_stall_idle", {31'h0, stall_mem}, 32'h1);
    chk("lb_req_idle", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("lb_req_w0", {31'h0, dmem_req}, 32'h1);
    chk("lb_stall_w0", {31'h0, stall_mem}, 32'h1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_we", {31'h0, dmem_we}, 32'h0);
    chk("lb_be", {28'h0, dmem_be}, 32'h8);
    chk("lb_bubble", {31'h0, wb_regwrite}, 32'h0);
    tick();
    chk("lb_stall_w1", {31'h0, stall_mem}, 32'h1);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("lb_stall_ack", {31'h0, stall_mem}, 32'h0);
    chk("lb_req_ack", {31'h0, dmem_req}, 32'h1);
    tick();
    dmem_ack = 1'b0;
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_towrite", {27'h0, wb_towrite}, 32'd7);
    chk("lb_wb_regwrite", {31'h0, wb_regwrite}, 32'h1);

    // lbu same address, immediate ack (2-edge latency)
    set_op(6'b100100, 32'h0000_0103, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
    #1;
    chk("lbu_stall_idle", {31'h0, stall_mem}, 32'h1);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("lbu_stall_ack", {31'h0, stall_mem}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("lbu_wb_data", wb_data, 32'h0000_0080);
    chk("lbu_wb_regwrite", {31'h0, wb_regwrite}, 32'h1);

    // sh 0x202 with MemtoReg also set: store wins, no writeback
    set_op(6'b101001, 32'h0000_0202, 32'h0000_ABCD, 1'b1, 1'b1, 1'b1, 5'd3);
    #1;
    chk("sh_stall_idle", {31'h0, stall_mem}, 32'h1);
    tick();
    chk("sh_req", {31'h0, dmem_req}, 32'h1);
    chk("sh_we", {31'h0, dmem_we}, 32'h1);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    chk("sh_be", {28'h0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sh_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);

    // lw 0x101 misaligned
    set_op(6'b100011, 32'h0000_0101, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4);
    #1;
    chk("lw_mis_stall", {31'h0, stall_mem}, 32'h0);
    chk("lw_mis_req", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("lw_mis_pulse", {31'h0, misalign}, 32'h1);
    chk("lw_mis_regwrite", {31'h0, wb_regwrite}, 32'h0);
    chk("lw_mis_req_after", {31'h0, dmem_req}, 32'h0);
    set_op(6'b000000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("lw_mis_pulse_end", {31'h0, misalign}, 32'h0);

    // sw 0x300, ack never arrives
    set_op(6'b101011, 32'h0000_0300, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("sw_to_stall_idle", {31'h0, stall_mem}, 32'h1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("sw_to_req_w%0d", k), {31'h0, dmem_req}, 32'h1);
      chk($sformatf("sw_to_stall_w%0d", k), {31'h0, stall_mem}, 32'h1);
    end
    chk("sw_to_be", {28'h0, dmem_be}, 32'hF);
    chk("sw_to_wdata", dmem_wdata, 32'h1122_3344);
    tick();
    chk("sw_to_req_drop", {31'h0, dmem_req}, 32'h0);
    chk("sw_to_stall_drop", {31'h0, stall_mem}, 32'h0);
    chk("sw_to_no_err_yet", {31'h0, bus_err}, 32'h0);
    set_op(6'b000000, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    chk("sw_to_bus_err", {31'h0, bus_err}, 32'h1);
    chk("sw_to_bubble", {31'h0, wb_regwrite}, 32'h0);
    chk("sw_to_req_idle", {31'h0, dmem_req}, 32'h0);
    chk("sw_to_stall_idle2", {31'h0, stall_mem}, 32'h0);
    tick();
    chk("post_to_wb_data", wb_data, 32'h0000_0055);
    chk("post_to_regwrite", {31'h0, wb_regwrite}, 32'h1);
    chk("post_to_bus_err_end", {31'h0, bus_err}, 32'h0);

    // sw 0x400, reset in WAIT cycle 3
    set_op(6'b101011, 32'h0000_0400, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (4) tick();
    chk("rstw_req_before", {31'h0, dmem_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rstw_req", {31'h0, dmem_req}, 32'h0);
    chk("rstw_stall", {31'h0, stall_mem}, 32'h0);
    chk("rstw_wb_data", wb_data, 32'h0);
    chk("rstw_wb_towrite", {27'h0, wb_towrite}, 32'h0);
    chk("rstw_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);
    tick();
    set_op(6'b000000, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2);
    reset = 1'b0;
    #1;
    chk("rstw_alu_stall", {31'h0, stall_mem}, 32'h0);
    chk("rstw_alu_req", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("rstw_alu_wb_data", wb_data, 32'h0000_0077);
    chk("rstw_alu_towrite", {27'h0, wb_towrite}, 32'd2);
    chk("rstw_alu_regwrite", {31'h0, wb_regwrite}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
